// File: rtl/aes_enc_sequencer_if.sv
// Requester, AES-core and result signals of the AES encryption sequencer.
// The sequencer connects as slave; the surrounding system (requesters, core, consumer) as master.
interface aes_enc_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [127:0]     req0_data;
  logic [127:0]     req0_key;
  logic             req1_valid;
  logic             req1_ready;
  logic [127:0]     req1_data;
  logic [127:0]     req1_key;
  logic [127:0]     core_plain;
  logic [127:0]     core_key;
  logic [127:0]     core_cipher;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic             out_id;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  req0_valid, req0_data, req0_key,
    input  req1_valid, req1_data, req1_key,
    input  core_cipher, out_ready,
    output req0_ready, req1_ready,
    output core_plain, core_key,
    output out_valid, out_data, out_id, busy, op_count
  );

  modport master (
    output req0_valid, req0_data, req0_key,
    output req1_valid, req1_data, req1_key,
    output core_cipher, out_ready,
    input  req0_ready, req1_ready,
    input  core_plain, core_key,
    input  out_valid, out_data, out_id, busy, op_count
  );
endinterface

// File: rtl/aes_enc_sequencer.sv
// Round-robin front end for a combinational AES-128 core: registers the winning block onto the
// core, waits SETTLE_CYC cycles for the multicycle path, then returns the cipher with a valid/ready.
module aes_enc_sequencer #(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned CNT_W      = 16
) (
  input logic                Clk,
  input logic                Rst,
  aes_enc_sequencer_if.slave bus
);

  // 0 behaves as 1; values above the 4-bit counter range are clamped
  localparam int unsigned SETTLE_EFF = (SETTLE_CYC == 0) ? 1 :
                                       ((SETTLE_CYC > 15) ? 15 : SETTLE_CYC);
  localparam logic [3:0]  CNT_LOAD   = 4'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             rr_ptr;
  logic             id;
  logic [3:0]       cnt;
  logic [127:0]     core_plain;
  logic [127:0]     core_key;
  logic [127:0]     out_data;
  logic             out_valid;
  logic             out_id;
  logic [CNT_W-1:0] op_count;

  logic             grant_sel;
  logic             req0_ready;
  logic             req1_ready;
  logic             accept;
  logic             capture;
  logic             retire;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant_sel  = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE: begin
        // req1 wins when it is the only requester or when both ask and it is req1's turn
        grant_sel  = bus.req1_valid & (~bus.req0_valid | rr_ptr);
        req0_ready = bus.req0_valid & ~grant_sel;
        req1_ready = bus.req1_valid & grant_sel;
        accept     = bus.req0_valid | bus.req1_valid;
        if (accept) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          retire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rr_ptr     <= 1'b0;
      id         <= 1'b0;
      cnt        <= '0;
      core_plain <= '0;
      core_key   <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_id     <= 1'b0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        core_plain <= grant_sel ? bus.req1_data : bus.req0_data;
        core_key   <= grant_sel ? bus.req1_key  : bus.req0_key;
        id         <= grant_sel;
        rr_ptr     <= ~grant_sel;
        cnt        <= CNT_LOAD;
      end else if (state == SETTLE && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        out_data  <= bus.core_cipher;
        out_id    <= id;
        out_valid <= 1'b1;
      end
      if (retire) begin
        out_valid <= 1'b0;
        op_count  <= op_count + 1'b1;
      end
    end
  end

  assign bus.req0_ready = req0_ready;
  assign bus.req1_ready = req1_ready;
  assign bus.core_plain = core_plain;
  assign bus.core_key   = core_key;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_data;
  assign bus.out_id     = out_id;
  assign bus.busy       = (state != IDLE);
  assign bus.op_count   = op_count;

endmodule

// File: tb/tb_aes_enc_sequencer.sv
// Bench for aes_enc_sequencer: behavioural AES-128 core plus a scoreboard fed at each accept
// and drained by an output monitor; directed scenarios followed by randomized traffic.
module tb_aes_enc_sequencer;

  localparam int unsigned S  = 4;
  localparam int unsigned CW = 4;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_enc_sequencer_if #(.CNT_W(CW)) bus ();
  aes_enc_sequencer #(.SETTLE_CYC(S), .CNT_W(CW)) dut (.Clk(clk), .Rst(rst_n), .bus(bus));

  // ---------------- AES-128 reference ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // inverse as x^254 in GF(2^8), then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, sq;
    inv = 8'h01;
    sq  = x;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) inv = gmul(inv, sq);
      sq = gmul(sq, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] blk;
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    blk = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox(blk[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[row+4*c] = s[row+4*((c+row)%4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = t[i];
      blk = blk ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return blk;
  endfunction

  assign bus.core_cipher = aes128(bus.core_plain, bus.core_key);

  // ---------------- checking ----------------
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk_w(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic chk_i(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  typedef struct {
    logic [127:0] data;
    logic         id;
    int unsigned  acc_cyc;
  } exp_t;

  exp_t        sb [$];
  int unsigned cyc = 0;
  int unsigned n_acc = 0;
  int unsigned n_done = 0;
  logic        rr_model = 1'b0;
  logic        g;
  exp_t        e_in;

  always @(posedge clk) cyc <= cyc + 1;

  // Accept side: arbitration rule check and scoreboard push
  always @(negedge clk) begin
    if (!rst_n) begin
      n_acc    = 0;
      rr_model = 1'b0;
    end else begin
      if (n_acc == n_done) begin
        if (bus.req0_valid && bus.req1_valid)
          chk_i("arb_both", int'({bus.req0_ready, bus.req1_ready}), rr_model ? 1 : 2);
        else if (bus.req0_valid)
          chk_i("arb_only0", int'({bus.req0_ready, bus.req1_ready}), 2);
        else if (bus.req1_valid)
          chk_i("arb_only1", int'({bus.req0_ready, bus.req1_ready}), 1);
      end else begin
        chk_i("ready_while_busy", int'({bus.req0_ready, bus.req1_ready}), 0);
      end
      if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
        g            = bus.req1_valid && bus.req1_ready;
        e_in.data    = g ? aes128(bus.req1_data, bus.req1_key) : aes128(bus.req0_data, bus.req0_key);
        e_in.id      = g;
        e_in.acc_cyc = cyc + 1;
        sb.push_back(e_in);
        n_acc++;
        rr_model = ~g;
      end
    end
  end

  // Result side: latency, data, id and completion count
  logic        prev_ov = 1'b0;
  int unsigned op_model = 0;
  exp_t        e_out;

  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      n_done   = 0;
      op_model = 0;
      prev_ov  = 1'b0;
      sb.delete();
    end else begin
      if (bus.out_valid && !prev_ov) begin
        if (sb.size() == 0) chk_i("unexpected_out_valid", 1, 0);
        else chk_i("latency", int'(cyc - sb[0].acc_cyc), int'(S));
      end
      if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
        e_out = sb.pop_front();
        chk_w("out_data", bus.out_data, e_out.data);
        chk_i("out_id", int'(bus.out_id), int'(e_out.id));
        chk_i("op_count", int'(bus.op_count), int'(op_model % (1 << CW)));
        op_model++;
        n_done++;
      end
      prev_ov = bus.out_valid;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_req(input int idx, input logic v, input logic [127:0] d, input logic [127:0] k);
    if (idx == 0) begin
      bus.req0_valid = v; bus.req0_data = d; bus.req0_key = k;
    end else begin
      bus.req1_valid = v; bus.req1_data = d; bus.req1_key = k;
    end
  endtask

  task automatic upd_req(input int idx, input bit accepted, input bit more,
                         input int unsigned p_valid, input int unsigned p_drop);
    logic cur;
    cur = (idx == 0) ? bus.req0_valid : bus.req1_valid;
    if (!more) begin
      if (idx == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
    end else if (accepted || !cur) begin
      set_req(idx, $urandom_range(99) < p_valid, rnd128(), rnd128());
    end else if ($urandom_range(99) < p_drop) begin
      if (idx == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
    end
  endtask

  task automatic run_traffic(input int unsigned n, input int unsigned p_valid,
                             input int unsigned p_ready, input int unsigned p_drop,
                             input int unsigned max_cyc);
    int unsigned issued;
    bit a0, a1;
    issued = 0;
    for (int unsigned c = 0; c < max_cyc && issued < n; c++) begin
      @(negedge clk);
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      issued += int'(a0) + int'(a1);
      @(posedge clk);
      #1;
      upd_req(0, a0, issued < n, p_valid, p_drop);
      upd_req(1, a1, issued < n, p_valid, p_drop);
      bus.out_ready = ($urandom_range(99) < p_ready);
    end
    if (issued < n) chk_i("traffic_timeout", int'(issued), int'(n));
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      if (sb.size() == 0 && n_acc == n_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk_i("drain_timeout", int'(sb.size()), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ov(input int unsigned limit, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk_i("wait_out_valid_timeout", 0, 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_i("rst_out_valid", int'(bus.out_valid), 0);
    chk_i("rst_busy", int'(bus.busy), 0);
    chk_i("rst_op_count", int'(bus.op_count), 0);
    chk_i("rst_out_id", int'(bus.out_id), 0);
    chk_w("rst_out_data", bus.out_data, '0);
    chk_w("rst_core_plain", bus.core_plain, '0);
    chk_w("rst_core_key", bus.core_key, '0);
    @(posedge clk); #2; rst_n = 1'b1;

    // reset during the second SETTLE cycle loses the block
    @(posedge clk); #1; set_req(0, 1'b1, rnd128(), rnd128());
    @(posedge clk); #1; bus.req0_valid = 1'b0;
    @(posedge clk); #2; rst_n = 1'b0;
    #1;
    chk_i("abort_out_valid", int'(bus.out_valid), 0);
    chk_i("abort_busy", int'(bus.busy), 0);
    chk_i("abort_op_count", int'(bus.op_count), 0);
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;

    // FIPS-197 vector, plaintext cleared right after accept
    bus.out_ready = 1'b1;
    @(posedge clk); #1; set_req(0, 1'b1, FIPS_PT, FIPS_KEY);
    @(posedge clk); #1; set_req(0, 1'b0, '0, FIPS_KEY);
    wait_ov(20, ok);
    if (ok) begin
      chk_w("fips_cipher", bus.out_data, FIPS_CT);
      chk_i("fips_id", int'(bus.out_id), 0);
    end
    drain();

    // both requesters always valid: grants must alternate
    run_traffic(4, 100, 100, 0, 200);
    drain();
    chk_i("op_count_after_alt", int'(bus.op_count), 5);

    // consumer stalls for 10 cycles in DONE
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    set_req(0, 1'b1, rnd128(), rnd128());
    set_req(1, 1'b1, rnd128(), rnd128());
    wait_ov(20, ok);
    if (ok) begin
      for (int i = 0; i < 10; i++) begin
        if (sb.size() != 0) chk_w("hold_out_data", bus.out_data, sb[0].data);
        chk_i("hold_ready", int'({bus.req0_ready, bus.req1_ready}), 0);
        chk_i("hold_busy", int'(bus.busy), 1);
        @(negedge clk);
      end
    end
    @(posedge clk); #1;
    bus.out_ready  = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk); #1;
    chk_i("release_idle", int'(bus.busy), 0);
    drain();

    // randomized traffic, long enough for op_count to wrap
    run_traffic(30, 60, 70, 15, 3000);
    drain();
    chk_i("op_count_final", int'(bus.op_count), int'(36 % (1 << CW)));
    chk_i("sb_empty", int'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
